// File: rtl/prbs_checker.sv
`default_nettype none
// ============================================================================
//  Module   : prbs_checker
//  Purpose  : Self-synchronising PRBS checker with flywheel prediction,
//             lock/loss-of-lock tracking and a saturating error counter.
//  Revision : 1.0  initial release
// ============================================================================
module prbs_checker #(
  parameter int ORDER       = 5,
  parameter int TAP         = 2,
  parameter int LOCK_CNT    = 16,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic             rx_bit,
  input  logic             clr_count,
  output logic             locked,
  output logic             bit_error,
  output logic [ERR_W-1:0] error_count
);

  localparam int C_FILL_W  = $clog2(ORDER + 1);
  localparam int C_MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int C_POS_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int C_WERR_W  = $clog2(LOSS_THRESH + 1);

  localparam logic [C_FILL_W-1:0]  C_FILL_LAST  = C_FILL_W'(ORDER - 1);
  localparam logic [C_MATCH_W-1:0] C_MATCH_LAST = C_MATCH_W'(LOCK_CNT - 1);
  localparam logic [C_POS_W-1:0]   C_POS_LAST   = C_POS_W'(WINDOW - 1);
  localparam logic [C_WERR_W-1:0]  C_LOSS       = C_WERR_W'(LOSS_THRESH);

  localparam logic [1:0] C_FILL   = 2'd0;
  localparam logic [1:0] C_SEARCH = 2'd1;
  localparam logic [1:0] C_LOCKED = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [ORDER-1:0]     hist_q, hist_d;
  logic [C_FILL_W-1:0]  fill_q, fill_d;
  logic [C_MATCH_W-1:0] match_q, match_d;
  logic [C_POS_W-1:0]   pos_q, pos_d;
  logic [C_WERR_W-1:0]  werr_q, werr_d;
  logic [ERR_W-1:0]     cnt_q, cnt_d;
  logic                 locked_q;
  logic                 bit_error_q, bit_error_d;

  logic                 w_pred;
  logic                 w_mismatch;
  logic [C_WERR_W-1:0]  w_werr_inc;

  assign w_pred     = hist_q[TAP-1] ^ hist_q[ORDER-1];
  assign w_mismatch = rx_bit ^ w_pred;
  assign w_werr_inc = werr_q + C_WERR_W'(w_mismatch);

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    match_d     = match_q;
    pos_d       = pos_q;
    werr_d      = werr_q;
    cnt_d       = cnt_q;
    bit_error_d = 1'b0;
    if (rx_valid) begin
      case (state_q)
        C_FILL: begin
          hist_d = {hist_q[ORDER-2:0], rx_bit};
          if (fill_q == C_FILL_LAST) begin
            state_d = C_SEARCH;
            fill_d  = '0;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        C_SEARCH: begin
          hist_d = {hist_q[ORDER-2:0], rx_bit};
          // An all-zero history predicts zero forever, so it never counts as a match
          if (!w_mismatch && (hist_q != '0)) begin
            if (match_q == C_MATCH_LAST) begin
              state_d = C_LOCKED;
              match_d = '0;
              pos_d   = '0;
              werr_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
        C_LOCKED: begin
          // Flywheel: the prediction, not the received bit, feeds the history
          hist_d      = {hist_q[ORDER-2:0], w_pred};
          bit_error_d = w_mismatch;
          if (w_mismatch && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
          if (w_werr_inc == C_LOSS) begin
            state_d = C_FILL;
            hist_d  = '0;
            fill_d  = '0;
            match_d = '0;
            pos_d   = '0;
            werr_d  = '0;
          end else if (pos_q == C_POS_LAST) begin
            pos_d  = '0;
            werr_d = '0;
          end else begin
            pos_d  = pos_q + 1'b1;
            werr_d = w_werr_inc;
          end
        end
        default: state_d = C_FILL;
      endcase
    end
    if (clr_count) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= C_FILL;
      hist_q      <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      pos_q       <= '0;
      werr_q      <= '0;
      cnt_q       <= '0;
      locked_q    <= 1'b0;
      bit_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      pos_q       <= pos_d;
      werr_q      <= werr_d;
      cnt_q       <= cnt_d;
      locked_q    <= (state_d == C_LOCKED);
      bit_error_q <= bit_error_d;
    end
  end

  assign locked      = locked_q;
  assign bit_error   = bit_error_q;
  assign error_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prbs_checker
//  Purpose  : Scoreboard bench for prbs_checker (ERR_W=16 and ERR_W=4 copies).
//  Revision : 1.0  initial release
// ============================================================================
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic        rx_bit = 1'b0;
  logic        clr_count = 1'b0;
  logic        locked, bit_error, locked4, bit_error4;
  logic [15:0] error_count;
  logic [3:0]  error_count4;

  typedef struct packed {
    logic        err;
    logic        lock;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_cnt = 0;
  logic [4:0]  gh = '0;
  int          gen_n = 0;

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_bit(rx_bit),
    .clr_count(clr_count), .locked(locked), .bit_error(bit_error),
    .error_count(error_count)
  );

  prbs_checker #(.ERR_W(4)) dut4 (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_bit(rx_bit),
    .clr_count(clr_count), .locked(locked4), .bit_error(bit_error4),
    .error_count(error_count4)
  );

  function automatic logic [3:0] sat4(input logic [15:0] v);
    return (v > 16'd15) ? 4'hF : v[3:0];
  endfunction

  // Reference generator: seed 1,0,0,0,0 then b[n] = b[n-2] ^ b[n-5]
  function logic gen_next();
    logic b;
    if (gen_n < 5) b = (gen_n == 0);
    else           b = gh[1] ^ gh[4];
    gh    = {gh[3:0], b};
    gen_n = gen_n + 1;
    return b;
  endfunction

  task automatic drive(input logic v, input logic b, input logic clr,
                       input logic err, input logic lock);
    exp_t e;
    if (clr)      exp_cnt = 0;
    else if (err) exp_cnt = exp_cnt + 1;
    e.err  = err;
    e.lock = lock;
    e.cnt  = 16'(exp_cnt);
    sb.push_back(e);
    rx_valid  = v;
    rx_bit    = b;
    clr_count = clr;
    @(posedge clk);
    #1;
    rx_valid  = 1'b0;
    clr_count = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    rx_valid  = 1'b0;
    rx_bit    = 1'b0;
    clr_count = 1'b0;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    exp_cnt = 0;
    gen_n   = 0;
    gh      = '0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({locked, bit_error, error_count, locked4, bit_error4, error_count4} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset: got lock=%b err=%b cnt=%0d lock4=%b err4=%b cnt4=%0d, expected all 0",
               locked, bit_error, error_count, locked4, bit_error4, error_count4);
    end
  endtask

  task automatic test_clean_lock();
    exp_t e;
    do_reset();
    for (int i = 1; i <= 1000; i++) begin
      drive(1'b1, gen_next(), 1'b0, 1'b0, i >= 21);
      e = sb.pop_front();
      n_checks++;
      if ({bit_error, locked, error_count, bit_error4, locked4, error_count4} !==
          {e.err, e.lock, e.cnt, e.err, e.lock, sat4(e.cnt)}) begin
        n_fail++;
        $display("FAIL clean_lock bit %0d: got err=%b lock=%b cnt=%0d err4=%b lock4=%b cnt4=%0d, expected err=%b lock=%b cnt=%0d cnt4=%0d",
                 i, bit_error, locked, error_count, bit_error4, locked4, error_count4, e.err, e.lock, e.cnt, sat4(e.cnt));
      end
    end
  endtask

  task automatic test_single_error();
    exp_t e;
    logic inv;
    for (int i = 1; i <= 40; i++) begin
      inv = (i == 10);
      drive(1'b1, gen_next() ^ inv, 1'b0, inv, 1'b1);
      e = sb.pop_front();
      n_checks++;
      if ({bit_error, locked, error_count, bit_error4, locked4, error_count4} !==
          {e.err, e.lock, e.cnt, e.err, e.lock, sat4(e.cnt)}) begin
        n_fail++;
        $display("FAIL single_error bit %0d: got err=%b lock=%b cnt=%0d err4=%b lock4=%b cnt4=%0d, expected err=%b lock=%b cnt=%0d cnt4=%0d",
                 i, bit_error, locked, error_count, bit_error4, locked4, error_count4, e.err, e.lock, e.cnt, sat4(e.cnt));
      end
    end
  endtask

  task automatic test_loss_of_lock();
    exp_t e;
    logic inv, lock;
    do_reset();
    for (int i = 1; i <= 58; i++) begin
      if (i <= 21) begin
        inv  = 1'b0;
        lock = (i >= 21);
      end else if (i <= 37) begin
        inv  = ((i - 21) % 2 == 0);
        lock = ((i - 21) < 16);
      end else begin
        inv  = 1'b0;
        lock = ((i - 37) >= 21);
      end
      drive(1'b1, gen_next() ^ inv, 1'b0, inv, lock);
      e = sb.pop_front();
      n_checks++;
      if ({bit_error, locked, error_count, bit_error4, locked4, error_count4} !==
          {e.err, e.lock, e.cnt, e.err, e.lock, sat4(e.cnt)}) begin
        n_fail++;
        $display("FAIL loss_of_lock bit %0d: got err=%b lock=%b cnt=%0d err4=%b lock4=%b cnt4=%0d, expected err=%b lock=%b cnt=%0d cnt4=%0d",
                 i, bit_error, locked, error_count, bit_error4, locked4, error_count4, e.err, e.lock, e.cnt, sat4(e.cnt));
      end
    end
  endtask

  // 7 errors in each of three consecutive windows; ERR_W=4 copy saturates at 15
  task automatic test_window_and_saturation();
    exp_t e;
    logic inv;
    int   j;
    do_reset();
    for (int i = 1; i <= 161; i++) begin
      j   = i - 21;
      inv = (j >= 1 && j <= 7) || (j >= 65 && j <= 71) || (j >= 129 && j <= 135);
      drive(1'b1, gen_next() ^ inv, 1'b0, inv, i >= 21);
      e = sb.pop_front();
      n_checks++;
      if ({bit_error, locked, error_count, bit_error4, locked4, error_count4} !==
          {e.err, e.lock, e.cnt, e.err, e.lock, sat4(e.cnt)}) begin
        n_fail++;
        $display("FAIL window_sat bit %0d: got err=%b lock=%b cnt=%0d err4=%b lock4=%b cnt4=%0d, expected err=%b lock=%b cnt=%0d cnt4=%0d",
                 i, bit_error, locked, error_count, bit_error4, locked4, error_count4, e.err, e.lock, e.cnt, sat4(e.cnt));
      end
    end
  endtask

  task automatic test_gaps();
    exp_t e;
    logic inv;
    int   vc = 0;
    do_reset();
    for (int c = 0; c < 70; c++) begin
      if (c % 2 == 0) begin
        vc++;
        inv = (vc == 24);
        drive(1'b1, gen_next() ^ inv, 1'b0, inv, vc >= 21);
      end else begin
        drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, vc >= 21);
      end
      e = sb.pop_front();
      n_checks++;
      if ({bit_error, locked, error_count, bit_error4, locked4, error_count4} !==
          {e.err, e.lock, e.cnt, e.err, e.lock, sat4(e.cnt)}) begin
        n_fail++;
        $display("FAIL gaps cycle %0d: got err=%b lock=%b cnt=%0d err4=%b lock4=%b cnt4=%0d, expected err=%b lock=%b cnt=%0d cnt4=%0d",
                 c, bit_error, locked, error_count, bit_error4, locked4, error_count4, e.err, e.lock, e.cnt, sat4(e.cnt));
      end
    end
  endtask

  task automatic test_zeros();
    exp_t e;
    do_reset();
    for (int i = 1; i <= 200; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      n_checks++;
      if ({bit_error, locked, error_count, bit_error4, locked4, error_count4} !==
          {e.err, e.lock, e.cnt, e.err, e.lock, sat4(e.cnt)}) begin
        n_fail++;
        $display("FAIL zeros bit %0d: got err=%b lock=%b cnt=%0d err4=%b lock4=%b cnt4=%0d, expected err=%b lock=%b cnt=%0d cnt4=%0d",
                 i, bit_error, locked, error_count, bit_error4, locked4, error_count4, e.err, e.lock, e.cnt, sat4(e.cnt));
      end
    end
  endtask

  task automatic test_clr_priority();
    exp_t e;
    logic inv, clr;
    int   j;
    do_reset();
    for (int i = 1; i <= 27; i++) begin
      j   = i - 21;
      inv = (j == 2) || (j == 4);
      clr = (j == 2) || (j == 6);
      drive(1'b1, gen_next() ^ inv, clr, inv, i >= 21);
      e = sb.pop_front();
      n_checks++;
      if ({bit_error, locked, error_count, bit_error4, locked4, error_count4} !==
          {e.err, e.lock, e.cnt, e.err, e.lock, sat4(e.cnt)}) begin
        n_fail++;
        $display("FAIL clr_priority bit %0d: got err=%b lock=%b cnt=%0d err4=%b lock4=%b cnt4=%0d, expected err=%b lock=%b cnt=%0d cnt4=%0d",
                 i, bit_error, locked, error_count, bit_error4, locked4, error_count4, e.err, e.lock, e.cnt, sat4(e.cnt));
      end
    end
  endtask

  task automatic test_reset_locked();
    exp_t e;
    logic inv;
    do_reset();
    for (int i = 1; i <= 46; i++) begin
      if (i == 26) begin
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_bit   = ~gen_next();
        @(posedge clk);
        #1;
        reset    = 1'b0;
        rx_valid = 1'b0;
        exp_cnt  = 0;
        n_checks++;
        if ({locked, bit_error, error_count, locked4, bit_error4, error_count4} !== 24'd0) begin
          n_fail++;
          $display("FAIL reset_locked: got lock=%b err=%b cnt=%0d lock4=%b err4=%b cnt4=%0d, expected all 0",
                   locked, bit_error, error_count, locked4, bit_error4, error_count4);
        end
      end else begin
        inv = (i == 23);
        drive(1'b1, gen_next() ^ inv, 1'b0, inv, (i < 26) ? (i >= 21) : (i - 26 >= 21));
        e = sb.pop_front();
        n_checks++;
        if ({bit_error, locked, error_count, bit_error4, locked4, error_count4} !==
            {e.err, e.lock, e.cnt, e.err, e.lock, sat4(e.cnt)}) begin
          n_fail++;
          $display("FAIL reset_locked bit %0d: got err=%b lock=%b cnt=%0d err4=%b lock4=%b cnt4=%0d, expected err=%b lock=%b cnt=%0d cnt4=%0d",
                   i, bit_error, locked, error_count, bit_error4, locked4, error_count4, e.err, e.lock, e.cnt, sat4(e.cnt));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_of_lock();
    test_window_and_saturation();
    test_gaps();
    test_zeros();
    test_clr_priority();
    test_reset_locked();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
